// File: rtl/st_skid_stage_pkg.sv
// Shared constants for the skid-stage slices: FSM state encoding and the
// occupancy-count width helper.
package st_skid_stage_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    // Count must hold 0..2*dp; never narrower than one bit, even for dp=0.
    function automatic int calc_cw(input int dp);
        int w;
        w = $clog2(2 * dp + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/st_skid_stage_slice.sv
// One skid slice (main + skid register, 3-state FSM) and the enabled,
// async-reset register it is built from.
module reg_enrs #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module st_skid_slice
    import st_skid_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] data_i,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] data_o,
    output logic [1:0]    occ
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          in_hs;
    logic          out_hs;
    logic          main_en;
    logic          skid_en;
    logic [DW-1:0] main_d;
    logic [DW-1:0] skid_q;

    // Both handshake qualifiers decode straight from the state flops, so
    // nothing combinational reaches i_rdy or o_vld from the ports.
    assign i_rdy  = (state != ST_FULL);
    assign o_vld  = (state == ST_BUSY) || (state == ST_FULL);
    assign in_hs  = i_vld & i_rdy;
    assign out_hs = o_vld & o_rdy;
    assign occ    = {state == ST_FULL, state == ST_BUSY};

    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        case (state)
            ST_BUSY: begin
                if (in_hs && !out_hs) begin
                    skid_en   = 1'b1;
                    state_nxt = ST_FULL;
                end else if (out_hs && !in_hs) begin
                    state_nxt = ST_EMPTY;
                end else if (in_hs && out_hs) begin
                    main_en   = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_hs) begin
                    main_en   = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            default: begin
                // Covers EMPTY and the unreachable 2'b11, which behaves as EMPTY.
                state_nxt = ST_EMPTY;
                if (in_hs) begin
                    main_en   = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
        endcase
    end

    assign main_d = (state == ST_FULL) ? skid_q : data_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    reg_enrs #(.W(DW)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (data_o)
    );

    reg_enrs #(.W(DW)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (data_i),
        .q   (skid_q)
    );

endmodule

// File: rtl/st_skid_stage.sv
// Full-throughput valid/ready register slice chained DP deep; registers both
// the forward (valid/data) and backward (ready) paths.
module st_skid_stage
    import st_skid_stage_pkg::*;
#(
    parameter  int DW = 32,
    parameter  int DP = 1,
    localparam int CW = calc_cw(DP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] data_i,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] cnt
);

    generate
        if (DP == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign o_vld  = i_vld;
            assign i_rdy  = o_rdy;
            assign data_o = data_i;
            assign cnt    = '0;
        end else begin : g_chain
            logic          vld  [0:DP];
            logic          rdy  [0:DP];
            logic [DW-1:0] data [0:DP];
            logic [1:0]    occ  [0:DP-1];

            assign vld[0]  = i_vld;
            assign i_rdy   = rdy[0];
            assign data[0] = data_i;
            assign o_vld   = vld[DP];
            assign rdy[DP] = o_rdy;
            assign data_o  = data[DP];

            for (genvar k = 0; k < DP; k++) begin : g_slice
                st_skid_slice #(.DW(DW)) u_slice (
                    .clk    (clk),
                    .rst    (rst),
                    .i_vld  (vld[k]),
                    .i_rdy  (rdy[k]),
                    .data_i (data[k]),
                    .o_vld  (vld[k+1]),
                    .o_rdy  (rdy[k+1]),
                    .data_o (data[k+1]),
                    .occ    (occ[k])
                );
            end

            always_comb begin
                cnt = '0;
                for (int k = 0; k < DP; k++) begin
                    cnt = cnt + CW'(occ[k]);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_st_skid_stage.sv
// Directed and scoreboarded checks of st_skid_stage at DP=0,1,2,3.
module tb_st_skid_stage;

    localparam int DW = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic          v1_ivld, v1_irdy, v1_ovld, v1_ordy;
    logic [DW-1:0] v1_di, v1_do;
    logic [1:0]    v1_cnt;

    logic          v3_ivld, v3_irdy, v3_ovld, v3_ordy;
    logic [DW-1:0] v3_di, v3_do;
    logic [2:0]    v3_cnt;

    logic          v2_ivld, v2_irdy, v2_ovld, v2_ordy;
    logic [DW-1:0] v2_di, v2_do;
    logic [2:0]    v2_cnt;

    logic          v0_ivld, v0_irdy, v0_ovld, v0_ordy;
    logic [DW-1:0] v0_di, v0_do;
    logic [0:0]    v0_cnt;

    st_skid_stage #(.DW(DW), .DP(1)) u_dp1 (
        .clk(clk), .rst(rst), .i_vld(v1_ivld), .i_rdy(v1_irdy), .data_i(v1_di),
        .o_vld(v1_ovld), .o_rdy(v1_ordy), .data_o(v1_do), .cnt(v1_cnt));

    st_skid_stage #(.DW(DW), .DP(3)) u_dp3 (
        .clk(clk), .rst(rst), .i_vld(v3_ivld), .i_rdy(v3_irdy), .data_i(v3_di),
        .o_vld(v3_ovld), .o_rdy(v3_ordy), .data_o(v3_do), .cnt(v3_cnt));

    st_skid_stage #(.DW(DW), .DP(2)) u_dp2 (
        .clk(clk), .rst(rst), .i_vld(v2_ivld), .i_rdy(v2_irdy), .data_i(v2_di),
        .o_vld(v2_ovld), .o_rdy(v2_ordy), .data_o(v2_do), .cnt(v2_cnt));

    st_skid_stage #(.DW(DW), .DP(0)) u_dp0 (
        .clk(clk), .rst(rst), .i_vld(v0_ivld), .i_rdy(v0_irdy), .data_i(v0_di),
        .o_vld(v0_ovld), .o_rdy(v0_ordy), .data_o(v0_do), .cnt(v0_cnt));

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (v1_ovld !== 1'b0 || v1_irdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_held: o_vld=%b i_rdy=%b, expected 0/1", v1_ovld, v1_irdy);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (v1_ovld !== 1'b0 || v1_irdy !== 1'b1 || v1_cnt !== 2'd0 || v1_do !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_release: o_vld=%b i_rdy=%b cnt=%0d data_o=%h, expected 0/1/0/0000",
                     v1_ovld, v1_irdy, v1_cnt, v1_do);
        end
        v1_ivld = 1'b1;
        v1_di   = 16'h00A5;
        @(posedge clk);
        #1;
        v1_ivld = 1'b0;
        checks++;
        if (v1_ovld !== 1'b1 || v1_do !== 16'h00A5 || v1_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL reset_first_beat: o_vld=%b data_o=%h cnt=%0d, expected 1/00a5/1",
                     v1_ovld, v1_do, v1_cnt);
        end
        v1_ordy = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (v1_ovld !== 1'b0 || v1_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_drain: o_vld=%b cnt=%0d, expected 0/0", v1_ovld, v1_cnt);
        end
    endtask

    // Beat driven before edge e shows on the output after edge e+DP-1.
    task automatic test_streaming();
        logic exp_vld;
        v3_ordy = 1'b1;
        for (int e = 0; e < 105; e++) begin
            v3_ivld = (e < 100);
            v3_di   = 16'(e);
            @(posedge clk);
            #1;
            exp_vld = (e >= 2) && (e < 102);
            checks++;
            if (v3_ovld !== exp_vld) begin
                errors++;
                $display("[TB] FAIL stream_vld at %0d: o_vld=%b, expected %b", e, v3_ovld, exp_vld);
            end
            if (exp_vld) begin
                checks++;
                if (v3_do !== 16'(e - 2)) begin
                    errors++;
                    $display("[TB] FAIL stream_data at %0d: data_o=%0d, expected %0d", e, v3_do, e - 2);
                end
            end
            if (e < 100) begin
                checks++;
                if (v3_irdy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL stream_rdy at %0d: i_rdy=%b, expected 1", e, v3_irdy);
                end
            end
        end
        v3_ivld = 1'b0;
    endtask

    task automatic test_stall();
        v1_ordy = 1'b1;
        v1_ivld = 1'b1;
        v1_di   = 16'd1;
        @(posedge clk);
        #1;
        checks++;
        if (v1_ovld !== 1'b1 || v1_do !== 16'd1) begin
            errors++;
            $display("[TB] FAIL stall_first: o_vld=%b data_o=%0d, expected 1/1", v1_ovld, v1_do);
        end
        v1_di   = 16'd2;
        v1_ordy = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (v1_irdy !== 1'b0 || v1_cnt !== 2'd2 || v1_do !== 16'd1 || v1_ovld !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_full: i_rdy=%b cnt=%0d data_o=%0d o_vld=%b, expected 0/2/1/1",
                     v1_irdy, v1_cnt, v1_do, v1_ovld);
        end
        v1_di = 16'd3;
        @(posedge clk);
        #1;
        checks++;
        if (v1_irdy !== 1'b0 || v1_cnt !== 2'd2 || v1_do !== 16'd1) begin
            errors++;
            $display("[TB] FAIL stall_hold: i_rdy=%b cnt=%0d data_o=%0d, expected 0/2/1",
                     v1_irdy, v1_cnt, v1_do);
        end
        v1_ordy = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (v1_ovld !== 1'b1 || v1_do !== 16'd2 || v1_irdy !== 1'b1 || v1_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL stall_unstall: o_vld=%b data_o=%0d i_rdy=%b cnt=%0d, expected 1/2/1/1",
                     v1_ovld, v1_do, v1_irdy, v1_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (v1_ovld !== 1'b1 || v1_do !== 16'd3) begin
            errors++;
            $display("[TB] FAIL stall_beat3: o_vld=%b data_o=%0d, expected 1/3", v1_ovld, v1_do);
        end
        v1_di = 16'd4;
        @(posedge clk);
        #1;
        v1_ivld = 1'b0;
        checks++;
        if (v1_ovld !== 1'b1 || v1_do !== 16'd4) begin
            errors++;
            $display("[TB] FAIL stall_beat4: o_vld=%b data_o=%0d, expected 1/4", v1_ovld, v1_do);
        end
        @(posedge clk);
        #1;
        checks++;
        if (v1_ovld !== 1'b0 || v1_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL stall_empty: o_vld=%b cnt=%0d, expected 0/0", v1_ovld, v1_cnt);
        end
    endtask

    // Handshakes are predicted from the values visible just before each edge.
    task automatic test_random_backpressure();
        logic [DW-1:0] sb[$];
        int delivered;
        int cycles;
        delivered = 0;
        cycles    = 0;
        v2_ivld   = 1'b0;
        v2_ordy   = 1'b0;
        while ((delivered < 10000 || sb.size() != 0) && cycles < 60000) begin
            if (!(v2_ivld && !v2_irdy)) begin
                v2_ivld = (delivered < 10000) && ($urandom_range(0, 3) != 0);
                v2_di   = 16'($urandom);
            end
            v2_ordy = (delivered >= 10000) || ($urandom_range(0, 3) != 0);
            if (v2_ovld && v2_ordy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra_beat: data_o=%h delivered with 0 beats outstanding", v2_do);
                end else begin
                    if (v2_do !== sb[0]) begin
                        errors++;
                        $display("[TB] FAIL rand_data: data_o=%h, expected %h", v2_do, sb[0]);
                    end
                    void'(sb.pop_front());
                end
                delivered++;
            end
            if (v2_ivld && v2_irdy) begin
                sb.push_back(v2_di);
            end
            @(posedge clk);
            #1;
            cycles++;
            checks++;
            if (v2_cnt !== 3'(sb.size()) || v2_cnt > 3'd4) begin
                errors++;
                $display("[TB] FAIL rand_cnt: cnt=%0d, expected %0d (max 4)", v2_cnt, sb.size());
            end
        end
        v2_ivld = 1'b0;
        checks++;
        if (delivered < 10000 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_timeout: delivered=%0d outstanding=%0d, expected 10000/0",
                     delivered, sb.size());
        end
    endtask

    task automatic test_async_reset();
        v1_ordy = 1'b0;
        v1_ivld = 1'b1;
        v1_di   = 16'h0011;
        @(posedge clk);
        #1;
        v1_di = 16'h0022;
        @(posedge clk);
        #1;
        v1_ivld = 1'b0;
        checks++;
        if (v1_cnt !== 2'd2 || v1_irdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_prefull: cnt=%0d i_rdy=%b, expected 2/0", v1_cnt, v1_irdy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (v1_ovld !== 1'b0 || v1_irdy !== 1'b1 || v1_cnt !== 2'd0 || v1_do !== 16'h0) begin
            errors++;
            $display("[TB] FAIL areset_immediate: o_vld=%b i_rdy=%b cnt=%0d data_o=%h, expected 0/1/0/0000",
                     v1_ovld, v1_irdy, v1_cnt, v1_do);
        end
        @(negedge clk) rst = 1'b1;
        v1_ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (v1_ovld !== 1'b0 || v1_cnt !== 2'd0) begin
                errors++;
                $display("[TB] FAIL areset_stale %0d: o_vld=%b cnt=%0d, expected 0/0", i, v1_ovld, v1_cnt);
            end
        end
        v1_ivld = 1'b1;
        v1_di   = 16'h0033;
        @(posedge clk);
        #1;
        v1_ivld = 1'b0;
        checks++;
        if (v1_ovld !== 1'b1 || v1_do !== 16'h0033 || v1_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL areset_resume: o_vld=%b data_o=%h cnt=%0d, expected 1/0033/1",
                     v1_ovld, v1_do, v1_cnt);
        end
    endtask

    task automatic test_passthrough();
        logic          exp_rdy;
        logic          exp_vld;
        logic [DW-1:0] exp_data;
        for (int i = 0; i < 4; i++) begin
            exp_rdy  = (i % 2) == 1;
            exp_vld  = i < 2;
            exp_data = 16'h1000 + 16'(i * 16'h0111);
            v0_ordy  = exp_rdy;
            v0_ivld  = exp_vld;
            v0_di    = exp_data;
            #1;
            checks++;
            if (v0_irdy !== exp_rdy || v0_ovld !== exp_vld || v0_do !== exp_data || v0_cnt !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pass_%0d: i_rdy=%b o_vld=%b data_o=%h cnt=%0d, expected %b/%b/%h/0",
                         i, v0_irdy, v0_ovld, v0_do, v0_cnt, exp_rdy, exp_vld, exp_data);
            end
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b0;
        checks  = 0;
        errors  = 0;
        v1_ivld = 1'b0; v1_ordy = 1'b0; v1_di = '0;
        v3_ivld = 1'b0; v3_ordy = 1'b0; v3_di = '0;
        v2_ivld = 1'b0; v2_ordy = 1'b0; v2_di = '0;
        v0_ivld = 1'b0; v0_ordy = 1'b0; v0_di = '0;

        test_reset();
        test_streaming();
        test_stall();
        test_random_backpressure();
        test_async_reset();
        test_passthrough();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
